// File: rtl/rv32i_decoder.sv
// RV32I instruction decoder: zero-latency split of an instruction word into register
// addresses and datapath controls, plus a sticky flag recording any illegal instruction seen.
module rv32i_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic        rd_wr,
  output logic        is_pc,
  output logic [1:0]  op_b_sel,
  output logic [2:0]  alu_op,
  output logic [2:0]  imm_sel,
  output logic        mem_wr,
  output logic [3:0]  mask,
  output logic        unsign,
  output logic        is_load,
  output logic [1:0]  is_control,
  output logic [2:0]  bru_op,
  output logic        br_unsigned,
  output logic        illegal,
  output logic        illegal_seen
);

  // No handshake: a new instr may appear every cycle and outputs follow it combinationally.
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       bad;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    rs1_addr    = 5'd0;
    rs2_addr    = 5'd0;
    rd_addr     = 5'd0;
    rd_wr       = 1'b0;
    is_pc       = 1'b0;
    op_b_sel    = 2'b00;
    alu_op      = 3'b000;
    imm_sel     = 3'b000;
    mem_wr      = 1'b0;
    mask        = 4'b0000;
    unsign      = 1'b0;
    is_load     = 1'b0;
    is_control  = 2'b00;
    bru_op      = 3'b000;
    br_unsigned = 1'b0;
    bad         = 1'b0;

    case (opcode)
      OP_R: begin
        rs1_addr = instr[19:15];
        rs2_addr = instr[24:20];
        rd_addr  = instr[11:7];
        rd_wr    = 1'b1;
        if (funct7 == 7'b0100000)
          bad = !((funct3 == 3'b000) || (funct3 == 3'b101));
        else if (funct7 != 7'b0000000)
          bad = 1'b1;
      end
      OP_IMM: begin
        rs1_addr = instr[19:15];
        rd_addr  = instr[11:7];
        rd_wr    = 1'b1;
        op_b_sel = 2'b01;
        alu_op   = 3'b011;
        imm_sel  = 3'b001;
        // Only shifts reuse funct7; SRAI is the one legal non-zero pattern.
        if (funct3 == 3'b001)
          bad = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          bad = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
      end
      OP_LOAD: begin
        rs1_addr = instr[19:15];
        rd_addr  = instr[11:7];
        rd_wr    = 1'b1;
        is_load  = 1'b1;
        op_b_sel = 2'b01;
        alu_op   = 3'b100;
        imm_sel  = 3'b001;
        case (funct3)
          3'b000:  mask = 4'b0001;
          3'b001:  mask = 4'b0011;
          3'b010:  mask = 4'b1111;
          3'b100:  begin mask = 4'b0001; unsign = 1'b1; end
          3'b101:  begin mask = 4'b0011; unsign = 1'b1; end
          default: bad = 1'b1;
        endcase
      end
      OP_STORE: begin
        rs1_addr = instr[19:15];
        rs2_addr = instr[24:20];
        mem_wr   = 1'b1;
        op_b_sel = 2'b01;
        alu_op   = 3'b100;
        imm_sel  = 3'b010;
        case (funct3)
          3'b000:  mask = 4'b0001;
          3'b001:  mask = 4'b0011;
          3'b010:  mask = 4'b1111;
          default: bad = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        rs1_addr    = instr[19:15];
        rs2_addr    = instr[24:20];
        is_control  = 2'b01;
        is_pc       = 1'b1;
        op_b_sel    = 2'b01;
        alu_op      = 3'b100;
        imm_sel     = 3'b011;
        bru_op      = funct3;
        br_unsigned = funct3[1];
        bad         = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL: begin
        rd_addr    = instr[11:7];
        rd_wr      = 1'b1;
        is_control = 2'b10;
        is_pc      = 1'b1;
        op_b_sel   = 2'b01;
        alu_op     = 3'b100;
        imm_sel    = 3'b101;
      end
      OP_JALR: begin
        rs1_addr   = instr[19:15];
        rd_addr    = instr[11:7];
        rd_wr      = 1'b1;
        is_control = 2'b11;
        op_b_sel   = 2'b01;
        alu_op     = 3'b100;
        imm_sel    = 3'b001;
      end
      OP_LUI: begin
        rd_addr  = instr[11:7];
        rd_wr    = 1'b1;
        op_b_sel = 2'b01;
        alu_op   = 3'b101;
        imm_sel  = 3'b100;
      end
      OP_AUIPC: begin
        rd_addr  = instr[11:7];
        rd_wr    = 1'b1;
        is_pc    = 1'b1;
        op_b_sel = 2'b01;
        alu_op   = 3'b100;
        imm_sel  = 3'b100;
      end
      OP_FENCE, OP_SYSTEM: ;
      default: bad = 1'b1;
    endcase

    if (instr[1:0] != 2'b11)
      bad = 1'b1;

    // An illegal instruction must not disturb architectural state: kill every control.
    if (bad) begin
      rs1_addr    = 5'd0;
      rs2_addr    = 5'd0;
      rd_addr     = 5'd0;
      rd_wr       = 1'b0;
      is_pc       = 1'b0;
      op_b_sel    = 2'b00;
      alu_op      = 3'b000;
      imm_sel     = 3'b000;
      mem_wr      = 1'b0;
      mask        = 4'b0000;
      unsign      = 1'b0;
      is_load     = 1'b0;
      is_control  = 2'b00;
      bru_op      = 3'b000;
      br_unsigned = 1'b0;
    end
    illegal = bad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_seen <= 1'b0;
    else if (illegal)
      illegal_seen <= 1'b1;
  end

endmodule

// File: tb/tb_rv32i_decoder.sv
// Directed-vector bench for rv32i_decoder: decode fields per instruction plus the
// sticky illegal flag across clock edges and asynchronous reset.
module tb_rv32i_decoder;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rd_wr;
    logic       is_pc;
    logic [1:0] op_b_sel;
    logic [2:0] alu_op;
    logic [2:0] imm_sel;
    logic       mem_wr;
    logic [3:0] mask;
    logic       unsign;
    logic       is_load;
    logic [1:0] is_control;
    logic [2:0] bru_op;
    logic       br_unsigned;
    logic       illegal;
  } dec_t;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rd_wr, is_pc, mem_wr, unsign, is_load, br_unsigned, illegal, illegal_seen;
  logic [1:0]  op_b_sel, is_control;
  logic [2:0]  alu_op, imm_sel, bru_op;
  logic [3:0]  mask;

  int vectors;
  int miscompares;

  rv32i_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rd_addr      (rd_addr),
    .rd_wr        (rd_wr),
    .is_pc        (is_pc),
    .op_b_sel     (op_b_sel),
    .alu_op       (alu_op),
    .imm_sel      (imm_sel),
    .mem_wr       (mem_wr),
    .mask         (mask),
    .unsign       (unsign),
    .is_load      (is_load),
    .is_control   (is_control),
    .bru_op       (bru_op),
    .br_unsigned  (br_unsigned),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Builds an expected decode; arguments follow the dec_t field order.
  function automatic dec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic rd_wr_e, input logic is_pc_e, input logic [1:0] ob,
                              input logic [2:0] alu, input logic [2:0] imm, input logic mw,
                              input logic [3:0] msk, input logic uns, input logic ld,
                              input logic [1:0] ctl, input logic [2:0] bru, input logic bu,
                              input logic ill);
    dec_t d;
    d = '{rs1, rs2, rd, rd_wr_e, is_pc_e, ob, alu, imm, mw, msk, uns, ld, ctl, bru, bu, ill};
    return d;
  endfunction

  task automatic drive_and_check(input string tag, input logic [31:0] ins, input dec_t e);
    dec_t g;
    instr = ins;
    #1;
    g = '{rs1_addr, rs2_addr, rd_addr, rd_wr, is_pc, op_b_sel, alu_op, imm_sel, mem_wr,
          mask, unsign, is_load, is_control, bru_op, br_unsigned, illegal};
    if (g !== e) begin
      check({tag, ".rs1"},     32'(g.rs1),        32'(e.rs1));
      check({tag, ".rs2"},     32'(g.rs2),        32'(e.rs2));
      check({tag, ".rd"},      32'(g.rd),         32'(e.rd));
      check({tag, ".rd_wr"},   32'(g.rd_wr),      32'(e.rd_wr));
      check({tag, ".is_pc"},   32'(g.is_pc),      32'(e.is_pc));
      check({tag, ".op_b"},    32'(g.op_b_sel),   32'(e.op_b_sel));
      check({tag, ".alu"},     32'(g.alu_op),     32'(e.alu_op));
      check({tag, ".imm"},     32'(g.imm_sel),    32'(e.imm_sel));
      check({tag, ".mem_wr"},  32'(g.mem_wr),     32'(e.mem_wr));
      check({tag, ".mask"},    32'(g.mask),       32'(e.mask));
      check({tag, ".unsign"},  32'(g.unsign),     32'(e.unsign));
      check({tag, ".is_load"}, 32'(g.is_load),    32'(e.is_load));
      check({tag, ".ctl"},     32'(g.is_control), 32'(e.is_control));
      check({tag, ".bru"},     32'(g.bru_op),     32'(e.bru_op));
      check({tag, ".br_u"},    32'(g.br_unsigned),32'(e.br_unsigned));
      check({tag, ".illegal"}, 32'(g.illegal),    32'(e.illegal));
    end else begin
      check(tag, 64'(g), 64'(e));
    end
  endtask

  initial begin
    dec_t zero, ill;
    vectors     = 0;
    miscompares = 0;
    zero = mk(0, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 0, 4'b0000, 0, 0, 2'b00, 3'b000, 0, 0);
    ill  = mk(0, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 0, 4'b0000, 0, 0, 2'b00, 3'b000, 0, 1);
    instr = 32'h0000_0013;
    rst   = 1'b1;
    #2;
    check("reset.illegal_seen", 32'(illegal_seen), 32'd0);

    // Decode table, held under reset: outputs must not depend on rst.
    drive_and_check("addi",  32'h0641_0093, mk(2, 0, 1, 1, 0, 2'b01, 3'b011, 3'b001, 0, 4'b0000, 0, 0, 2'b00, 3'b000, 0, 0));
    drive_and_check("sub",   32'h4138_87B3, mk(17, 19, 15, 1, 0, 2'b00, 3'b000, 3'b000, 0, 4'b0000, 0, 0, 2'b00, 3'b000, 0, 0));
    drive_and_check("and",   32'h0137_F933, mk(15, 19, 18, 1, 0, 2'b00, 3'b000, 3'b000, 0, 4'b0000, 0, 0, 2'b00, 3'b000, 0, 0));
    drive_and_check("lh",    32'h0001_1083, mk(2, 0, 1, 1, 0, 2'b01, 3'b100, 3'b001, 0, 4'b0011, 0, 1, 2'b00, 3'b000, 0, 0));
    drive_and_check("lbu",   32'h0001_4083, mk(2, 0, 1, 1, 0, 2'b01, 3'b100, 3'b001, 0, 4'b0001, 1, 1, 2'b00, 3'b000, 0, 0));
    drive_and_check("lhu",   32'h0001_5083, mk(2, 0, 1, 1, 0, 2'b01, 3'b100, 3'b001, 0, 4'b0011, 1, 1, 2'b00, 3'b000, 0, 0));
    drive_and_check("bge",   32'hFE01_5CE3, mk(2, 0, 0, 0, 1, 2'b01, 3'b100, 3'b011, 0, 4'b0000, 0, 0, 2'b01, 3'b101, 0, 0));
    drive_and_check("bltu",  32'hFE01_6CE3, mk(2, 0, 0, 0, 1, 2'b01, 3'b100, 3'b011, 0, 4'b0000, 0, 0, 2'b01, 3'b110, 1, 0));
    drive_and_check("sw",    32'h0109_A823, mk(19, 16, 0, 0, 0, 2'b01, 3'b100, 3'b010, 1, 4'b1111, 0, 0, 2'b00, 3'b000, 0, 0));
    drive_and_check("jal",   32'h0080_01EF, mk(0, 0, 3, 1, 1, 2'b01, 3'b100, 3'b101, 0, 4'b0000, 0, 0, 2'b10, 3'b000, 0, 0));
    drive_and_check("jalr",  32'h01C6_0567, mk(12, 0, 10, 1, 0, 2'b01, 3'b100, 3'b001, 0, 4'b0000, 0, 0, 2'b11, 3'b000, 0, 0));
    drive_and_check("lui",   32'h1234_52B7, mk(0, 0, 5, 1, 0, 2'b01, 3'b101, 3'b100, 0, 4'b0000, 0, 0, 2'b00, 3'b000, 0, 0));
    drive_and_check("auipc", 32'h0000_0297, mk(0, 0, 5, 1, 1, 2'b01, 3'b100, 3'b100, 0, 4'b0000, 0, 0, 2'b00, 3'b000, 0, 0));
    drive_and_check("srai",  32'h4031_5093, mk(2, 0, 1, 1, 0, 2'b01, 3'b011, 3'b001, 0, 4'b0000, 0, 0, 2'b00, 3'b000, 0, 0));
    drive_and_check("fence", 32'h0000_000F, zero);
    drive_and_check("ecall", 32'h0000_0073, zero);
    drive_and_check("ill_ones",   32'hFFFF_FFFF, ill);
    drive_and_check("ill_ld_f3",  32'h0001_3083, ill);
    drive_and_check("ill_br_f3",  32'hFE01_2CE3, ill);
    drive_and_check("ill_sub_f3", 32'h4138_97B3, ill);
    drive_and_check("ill_slli",   32'h4031_1093, ill);
    drive_and_check("ill_low2",   32'h0641_0091, ill);
    drive_and_check("ill_opc",    32'h0000_002B, ill);
    drive_and_check("ill_st_f3",  32'h0109_B823, ill);

    // rst has priority: illegal instr across an edge while reset is high
    @(posedge clk); #1;
    check("rst_priority", 32'(illegal_seen), 32'd0);

    @(negedge clk);
    instr = 32'h0641_0093;
    rst   = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("legal_no_set", 32'(illegal_seen), 32'd0);

    @(negedge clk);
    instr = 32'hFFFF_FFFF;
    #1 check("comb_before_edge", 32'(illegal_seen), 32'd0);
    @(posedge clk); #1;
    check("set_on_edge", 32'(illegal_seen), 32'd1);

    @(negedge clk);
    instr = 32'h0109_A823;
    repeat (3) @(posedge clk);
    #1 check("sticky_hold", 32'(illegal_seen), 32'd1);

    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_clear", 32'(illegal_seen), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("stay_clear", 32'(illegal_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
